// File: rtl/fpu_arbiter_if.sv
// Bundle of requester and FPU-side signals around fpu_arbiter.
// slave = the arbiter; master = clients plus FPU instance (the environment).
interface fpu_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    op_in;
    logic [32*N_REQ-1:0] a_in;
    logic [32*N_REQ-1:0] b_in;
    logic [N_REQ-1:0]    grant;
    logic [N_REQ-1:0]    done;
    logic [31:0]         result;
    logic                err;
    logic                busy;
    logic                fpu_op;
    logic [31:0]         fpu_a;
    logic [31:0]         fpu_b;
    logic                fpu_en;
    logic [31:0]         fpu_c;
    logic                fpu_out_final;

    modport slave (
        input  req, op_in, a_in, b_in, fpu_c, fpu_out_final,
        output grant, done, result, err, busy, fpu_op, fpu_a, fpu_b, fpu_en
    );

    modport master (
        output req, op_in, a_in, b_in, fpu_c, fpu_out_final,
        input  grant, done, result, err, busy, fpu_op, fpu_a, fpu_b, fpu_en
    );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin scheduler sharing one fp add/sub unit between N_REQ requesters,
// with a watchdog that returns a quiet NaN and err if the FPU never answers.
module fpu_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    fpu_arbiter_if.slave   bus
);
    localparam int          CNT_W = $clog2(TIMEOUT + 1);
    localparam int          IDX_W = $clog2(N_REQ);
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    last_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [N_REQ-1:0]    grant_reg, done_reg;
    logic [31:0]         result_reg, fpu_a_reg, fpu_b_reg;
    logic                err_reg, busy_reg, fpu_op_reg, fpu_en_reg;

    logic [31:0]         a_arr [N_REQ];
    logic [31:0]         b_arr [N_REQ];
    logic [IDX_W:0]      cand_sum  [N_REQ];
    logic [IDX_W:0]      cand_wrap [N_REQ];
    logic [IDX_W-1:0]    cand_idx  [N_REQ];
    logic [N_REQ-1:0]    cand_req;
    logic [IDX_W-1:0]    win_idx;
    logic                win_found;
    logic [N_REQ-1:0]    win_onehot;
    logic                timeout_hit;

    // Candidate gi is the requester at distance gi+1 past the last winner.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign a_arr[gi]     = bus.a_in[32*gi +: 32];
            assign b_arr[gi]     = bus.b_in[32*gi +: 32];
            assign cand_sum[gi]  = {1'b0, last_reg} + (IDX_W+1)'(gi + 1);
            assign cand_wrap[gi] = (cand_sum[gi] >= (IDX_W+1)'(N_REQ))
                                 ? cand_sum[gi] - (IDX_W+1)'(N_REQ)
                                 : cand_sum[gi];
            assign cand_idx[gi]  = cand_wrap[gi][IDX_W-1:0];
            assign cand_req[gi]  = bus.req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest one wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[k];
            end
        end
    end

    assign win_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A completion coinciding with the last watchdog cycle still counts as success.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (win_found) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (bus.fpu_out_final || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_reg   <= IDX_W'(N_REQ - 1);
            cnt_reg    <= '0;
            grant_reg  <= '0;
            done_reg   <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            fpu_op_reg <= 1'b0;
            fpu_a_reg  <= '0;
            fpu_b_reg  <= '0;
            fpu_en_reg <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        last_reg   <= win_idx;
                        grant_reg  <= win_onehot;
                        fpu_op_reg <= bus.op_in[win_idx];
                        fpu_a_reg  <= a_arr[win_idx];
                        fpu_b_reg  <= b_arr[win_idx];
                    end
                end
                ISSUE: begin
                    cnt_reg <= '0;
                end
                WAIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (bus.fpu_out_final) begin
                        result_reg <= bus.fpu_c;
                        err_reg    <= 1'b0;
                    end else if (timeout_hit) begin
                        result_reg <= QNAN;
                        err_reg    <= 1'b1;
                    end
                end
                RESP: begin
                    grant_reg <= '0;
                    err_reg   <= 1'b0;
                end
                default: ;
            endcase
            // Status outputs follow the next state so they are registered yet in phase.
            busy_reg   <= (state_next != IDLE);
            fpu_en_reg <= (state_next == ISSUE);
            done_reg   <= (state_reg == WAIT && state_next == RESP) ? grant_reg : '0;
        end
    end

    assign bus.grant  = grant_reg;
    assign bus.done   = done_reg;
    assign bus.result = result_reg;
    assign bus.err    = err_reg;
    assign bus.busy   = busy_reg;
    assign bus.fpu_op = fpu_op_reg;
    assign bus.fpu_a  = fpu_a_reg;
    assign bus.fpu_b  = fpu_b_reg;
    assign bus.fpu_en = fpu_en_reg;
endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter: table-driven FPU model, one check line per failure.
module tb_fpu_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fpu_arbiter_if #(.N_REQ(N)) bus ();

    fpu_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] va [N];
    logic [31:0] vb [N];
    logic [31:0] vc [N];
    logic        vop [N];

    int n_chk  = 0;
    int n_pass = 0;

    // FPU model: answers from the vector table, out_final in WAIT cycle index lat.
    logic        of_m     = 1'b0;
    logic        force_of = 1'b0;
    logic        hang     = 1'b0;
    logic        pend_m   = 1'b0;
    logic [31:0] c_m      = 32'h0;
    int          lat      = 5;
    int          k_m      = 0;

    assign bus.fpu_out_final = of_m | force_of;
    assign bus.fpu_c         = c_m;

    function automatic logic [31:0] fpu_lookup(input logic op, input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < N; i++)
            if (vop[i] == op && va[i] == a && vb[i] == b) return vc[i];
        return 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) begin
        of_m <= 1'b0;
        if (bus.fpu_en && !hang) begin
            pend_m <= 1'b1;
            k_m    <= 1;
            c_m    <= fpu_lookup(bus.fpu_op, bus.fpu_a, bus.fpu_b);
        end else if (pend_m) begin
            if (k_m >= lat) begin
                of_m   <= 1'b1;
                pend_m <= 1'b0;
            end else begin
                k_m <= k_m + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_grant"},  32'(bus.grant), 32'h0);
        check({tag, "_done"},   32'(bus.done),  32'h0);
        check({tag, "_busy"},   32'(bus.busy),  32'h0);
        check({tag, "_err"},    32'(bus.err),   32'h0);
        check({tag, "_en"},     32'(bus.fpu_en), 32'h0);
        check({tag, "_result"}, bus.result,     32'h0);
        check({tag, "_a"},      bus.fpu_a,      32'h0);
        check({tag, "_b"},      bus.fpu_b,      32'h0);
        check({tag, "_op"},     32'(bus.fpu_op), 32'h0);
    endtask

    // Called on a negedge while IDLE with the request already pending.
    task automatic txn(input string tag, input logic [N-1:0] g_exp, input int lat_exp,
                       input logic [31:0] r_exp, input logic e_exp);
        int n;
        int idx;
        n   = 0;
        idx = 0;
        for (int i = 0; i < N; i++) if (g_exp[i]) idx = i;
        while (bus.grant == '0 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_gap"},   32'(n), 32'd1);
        check({tag, "_grant"}, 32'(bus.grant), 32'(g_exp));
        check({tag, "_en1"},   32'(bus.fpu_en), 32'd1);
        check({tag, "_busy"},  32'(bus.busy), 32'd1);
        check({tag, "_op"},    32'(bus.fpu_op), 32'(vop[idx]));
        check({tag, "_a"},     bus.fpu_a, va[idx]);
        check({tag, "_b"},     bus.fpu_b, vb[idx]);
        @(negedge clk);
        n = 1;
        check({tag, "_en0"}, 32'(bus.fpu_en), 32'd0);
        while (bus.done == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"},    32'(n), 32'(lat_exp));
        check({tag, "_done"},   32'(bus.done), 32'(g_exp));
        check({tag, "_result"}, bus.result, r_exp);
        check({tag, "_err"},    32'(bus.err), 32'(e_exp));
        check({tag, "_a_hold"}, bus.fpu_a, va[idx]);
        bus.req = bus.req & ~g_exp;
        @(negedge clk);
        check({tag, "_done0"},  32'(bus.done), 32'h0);
        check({tag, "_grant0"}, 32'(bus.grant), 32'h0);
        check({tag, "_busy0"},  32'(bus.busy), 32'h0);
        check({tag, "_err0"},   32'(bus.err), 32'h0);
        $display("txn %s grant=%b result=%h err=%0d latency=%0d", tag, g_exp, bus.result, bus.err, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // 1+2=3, 2+2=4, 3-1=2, 1+0.5=1.5
        va[0] = 32'h3F80_0000; vb[0] = 32'h4000_0000; vop[0] = 1'b0; vc[0] = 32'h4040_0000;
        va[1] = 32'h4000_0000; vb[1] = 32'h4000_0000; vop[1] = 1'b0; vc[1] = 32'h4080_0000;
        va[2] = 32'h4040_0000; vb[2] = 32'h3F80_0000; vop[2] = 1'b1; vc[2] = 32'h4000_0000;
        va[3] = 32'h3F80_0000; vb[3] = 32'h3F00_0000; vop[3] = 1'b0; vc[3] = 32'h3FC0_0000;
        bus.req = '0;
        for (int i = 0; i < N; i++) begin
            bus.a_in[32*i +: 32] = va[i];
            bus.b_in[32*i +: 32] = vb[i];
            bus.op_in[i]         = vop[i];
        end

        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        reset = 1'b1;

        // All four at once, held until done: 0,1,2,3
        bus.req = 4'b1111;
        txn("all_r0", 4'b0001, 7, 32'h4040_0000, 1'b0);
        txn("all_r1", 4'b0010, 7, 32'h4080_0000, 1'b0);
        txn("all_r2", 4'b0100, 7, 32'h4000_0000, 1'b0);
        txn("all_r3", 4'b1000, 7, 32'h3FC0_0000, 1'b0);

        bus.req = 4'b0001;
        txn("single", 4'b0001, 7, 32'h4040_0000, 1'b0);

        // Fairness after requester 2
        bus.req = 4'b0100;
        txn("fair_r2", 4'b0100, 7, 32'h4000_0000, 1'b0);
        bus.req = 4'b1101;
        txn("fair_r3", 4'b1000, 7, 32'h3FC0_0000, 1'b0);
        txn("fair_r0", 4'b0001, 7, 32'h4040_0000, 1'b0);
        txn("fair_r2b", 4'b0100, 7, 32'h4000_0000, 1'b0);

        // Hung FPU, then normal service
        hang    = 1'b1;
        bus.req = 4'b0010;
        txn("timeout", 4'b0010, TO + 1, 32'h7FC0_0000, 1'b1);
        hang    = 1'b0;
        bus.req = 4'b0100;
        txn("after_to", 4'b0100, 7, 32'h4000_0000, 1'b0);

        // out_final lands on the last watchdog cycle
        lat     = TO - 1;
        bus.req = 4'b1000;
        txn("coincide", 4'b1000, TO + 1, 32'h3FC0_0000, 1'b0);
        lat     = 5;

        force_of = 1'b1;
        @(negedge clk);
        force_of = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stray_done", 32'(bus.done), 32'h0);
            check("stray_busy", 32'(bus.busy), 32'h0);
            check("stray_result_hold", bus.result, 32'h3FC0_0000);
            @(negedge clk);
        end
        $display("txn stray_out_final done=%b busy=%0d", bus.done, bus.busy);

        // Reset in the middle of WAIT
        hang    = 1'b1;
        bus.req = 4'b0100;
        @(negedge clk);
        check("rst_pre_grant", 32'(bus.grant), 32'h4);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_idle_zero("rst_async");
        bus.req = 4'b1111;
        hang    = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_no_done", 32'(bus.done), 32'h0);
        end
        $display("txn reset_mid_wait grant=%b done=%b", bus.grant, bus.done);
        reset = 1'b1;
        txn("post_rst", 4'b0001, 7, 32'h4040_0000, 1'b0);

        bus.req = '0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Round-robin scheduler that shares one `fp_01` floating-point add/sub unit between `N_REQ` requesters. It latches the winning requester's operands and drives the FPU's `op/a/b/en` inputs. It then waits for `out_final`, captures `c`, and returns the result with a one-cycle `done` pulse. A watchdog bounds every transaction so a hung FPU cannot stall the requesters. The block sits between client logic and the FPU instance.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 64: maximum number of WAIT cycles before abort; must be at least 1.
- `clk`  input  1  system clock; all logic is rising-edge.
- `reset`  input  1  asynchronous, active-low reset.
- `req`  input  N_REQ  per-requester request level.
- `op_in`  input  N_REQ  per-requester operation bit (0 = add, 1 = sub, passed to FPU `op`).
- `a_in`  input  32*N_REQ  operand A; requester i occupies bits [32i+31:32i].
- `b_in`  input  32*N_REQ  operand B; same packing as `a_in`.
- `grant`  output  N_REQ  one-hot owner of the current transaction; all zero when IDLE.
- `done`  output  N_REQ  one-cycle completion pulse to the owner.
- `result`  output  32  captured FPU result; valid while `done` is nonzero and held until the next capture.
- `err`  output  1  high with `done` when the transaction timed out.
- `busy`  output  1  high in every state other than IDLE.
- `fpu_op`  output  1  drives FPU `op`.
- `fpu_a`, `fpu_b`  output  32  drive FPU `a` and `b`.
- `fpu_en`  output  1  drives FPU `en`.
- `fpu_c`  input  32  FPU `c`.
- `fpu_out_final`  input  1  FPU completion flag.

## Operation
- States are IDLE, ISSUE, WAIT and RESP, held in a 2-bit register.
- **IDLE:** if any `req` bit is high, pick the winner by round-robin and go to ISSUE.
  - The search starts at `last+1` modulo N_REQ.
  - `last` resets to N_REQ-1, so requester 0 wins first after reset.
  - In the same edge, latch that requester's `op_in`, `a_in` and `b_in` into `fpu_op`, `fpu_a` and `fpu_b`, set `grant`, and set `last` to the winner.
- **ISSUE:** `fpu_en` is 1 for exactly this one cycle. Clear the watchdog counter and go to WAIT.
- **WAIT:** the counter increments each cycle; its width is $clog2(TIMEOUT+1).
  - If `fpu_out_final` is 1: capture `fpu_c` into `result`, set `err` to 0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT-1 in this cycle: set `result` to 32'h7FC00000, set `err` to 1, go to RESP.
  - If `fpu_out_final` and the timeout coincide, `fpu_out_final` wins and `err` is 0.
- **RESP:** `done` equals `grant` for one cycle. Next state is IDLE, and `grant` and `err` clear on entry to IDLE.
- `fpu_op`, `fpu_a` and `fpu_b` stay stable from ISSUE through RESP.
- `fpu_out_final` is ignored in IDLE, ISSUE and RESP.
- The arbiter does not look at `req` after the grant. A requester that drops `req` mid-transaction still receives `done`, and the result is discarded by the client.
- Requester contract:
  - Hold `req` high with stable operands until `done` is seen.
  - Drop `req` in the cycle after `done`; otherwise a new transaction is arbitrated.
- **Reset (asynchronous, any state):**
  - State returns to IDLE and `last` to N_REQ-1.
  - `grant`, `done`, `err`, `busy` and `fpu_en` are 0.
  - `result`, `fpu_a` and `fpu_b` are 0; `fpu_op` is 0.
  - Any in-flight transaction is dropped and no `done` is issued.

## Timing
- `req` is sampled in IDLE at edge t. At t+1: ISSUE, `grant` valid, `fpu_en`=1.
- At t+2 and later: WAIT. If `fpu_out_final` is high in cycle k, then at k+1 RESP with `done` and `result` valid. At k+2: IDLE.
- Minimum issue-to-issue spacing for back-to-back transactions is 4 cycles plus the FPU latency.
- A timeout produces RESP exactly TIMEOUT cycles after WAIT entry.
- All outputs are registered; there is no combinational path from `req` or FPU inputs to any output.

## Test plan
1. Single request: `req`=0001, a=0x3F800000 (1.0), b=0x40000000 (2.0), op=0, FPU model returns c=0x40400000 after 5 cycles. Required: `grant`=0001 one cycle after `req`, `fpu_en` high for exactly 1 cycle, `done`=0001 with `result`=0x40400000 and `err`=0.
2. Four simultaneous requests held until `done`: required grant order 0,1,2,3. Each requester gets one `done`, and each `result` matches its own operands.
3. Fairness: after requester 2 is served, set `req`=1101. Required: next grant is 3, then 0, then 2.
4. Timeout: TIMEOUT=8, FPU never asserts `out_final`. Required: `done` 8 cycles after WAIT entry, `err`=1, `result`=0x7FC00000, then the next request is served normally.
5. `out_final` coinciding with the final timeout cycle: required `err`=0 and the real result is captured. A stray `out_final` during IDLE: required no `done`.
6. Reset asserted mid-WAIT: required all outputs return to 0 immediately (asynchronously), no `done` pulse, and requester 0 wins the first arbitration after release.
